// File: rtl/msx_slot_io_responder.sv
// MSX slot I/O responder: turns Z80 /IORQ+/RD or /WR cycles on four decoded ports
// into single valid/ready bus transactions, holding /WAIT on reads until data returns.
module msx_slot_io_responder #(
    parameter logic [7:0] IO_BASE       = 8'h88,
    parameter int         SETTLE_CYCLES = 4,
    parameter int         WAIT_TIMEOUT  = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       slot_iorq_n,
    input  logic       slot_rd_n,
    input  logic       slot_wr_n,
    input  logic [7:0] slot_a,
    input  logic [7:0] slot_d_in,
    output logic [7:0] slot_d_out,
    output logic       slot_data_dir,
    output logic       slot_wait,
    output logic [1:0] bus_address,
    output logic       bus_valid,
    output logic       bus_write,
    output logic [7:0] bus_wdata,
    input  logic       bus_ready,
    input  logic [7:0] bus_rdata,
    input  logic       bus_rdata_en,
    output logic       timeout_flag
);

    // Handshake: a transaction is transferred on every clk edge where bus_valid and
    // bus_ready are both 1; bus_write/bus_address/bus_wdata are held stable while
    // bus_valid=1 and bus_ready=0, and bus_valid never drops before that transfer.

    localparam int         TO_W        = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(WAIT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_REQ     = 3'd2,
        ST_RDWAIT  = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Strobe synchronizers, bit order {iorq, rd, wr}; reset to the inactive level.
    logic [2:0] strb_m_q;
    logic [2:0] strb_s_q;

    logic [3:0]      settle_cnt_q, settle_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            is_write_q, is_write_d;
    logic [1:0]      bus_address_q, bus_address_d;
    logic            bus_write_q, bus_write_d;
    logic [7:0]      bus_wdata_q, bus_wdata_d;
    logic [7:0]      d_out_q, d_out_d;
    logic            dir_q, dir_d;
    logic            wait_q, wait_d;
    logic            timeout_q, timeout_d;

    logic iorq_s, rd_s, wr_s;
    logic wr_act, rd_act, cur_act, all_idle;
    logic addr_match, settle_done, to_hit;

    assign iorq_s = strb_s_q[2];
    assign rd_s   = strb_s_q[1];
    assign wr_s   = strb_s_q[0];

    assign wr_act     = ~iorq_s & ~wr_s;
    assign rd_act     = ~iorq_s & ~rd_s;
    assign all_idle   = iorq_s & rd_s & wr_s;
    assign cur_act    = is_write_q ? wr_act : rd_act;
    assign addr_match = (slot_a[7:2] == IO_BASE[7:2]);
    assign settle_done = (settle_cnt_q >= SETTLE_LAST);
    assign to_hit     = (to_cnt_q >= TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            strb_m_q <= 3'b111;
            strb_s_q <= 3'b111;
        end else begin
            strb_m_q <= {slot_iorq_n, slot_rd_n, slot_wr_n};
            strb_s_q <= strb_m_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            settle_cnt_q  <= '0;
            to_cnt_q      <= '0;
            is_write_q    <= 1'b0;
            bus_address_q <= 2'd0;
            bus_write_q   <= 1'b0;
            bus_wdata_q   <= 8'h00;
            d_out_q       <= 8'hFF;
            dir_q         <= 1'b0;
            wait_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            settle_cnt_q  <= settle_cnt_d;
            to_cnt_q      <= to_cnt_d;
            is_write_q    <= is_write_d;
            bus_address_q <= bus_address_d;
            bus_write_q   <= bus_write_d;
            bus_wdata_q   <= bus_wdata_d;
            d_out_q       <= d_out_d;
            dir_q         <= dir_d;
            wait_q        <= wait_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        settle_cnt_d  = (settle_cnt_q == 4'hF) ? settle_cnt_q : settle_cnt_q + 4'd1;
        to_cnt_d      = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + 1'b1;
        is_write_d    = is_write_q;
        bus_address_d = bus_address_q;
        bus_write_d   = bus_write_q;
        bus_wdata_d   = bus_wdata_q;
        d_out_d       = d_out_q;
        dir_d         = dir_q;
        wait_d        = wait_q;
        timeout_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                settle_cnt_d = '0;
                if (wr_act || rd_act) begin
                    // Both strobes at once is illegal; the write wins.
                    state_d    = ST_SETTLE;
                    is_write_d = wr_act;
                    wait_d     = ~wr_act;
                end
            end
            ST_SETTLE: begin
                if (!cur_act) begin
                    state_d = ST_IDLE;
                    wait_d  = 1'b0;
                end else if (settle_done) begin
                    if (addr_match) begin
                        state_d       = ST_REQ;
                        bus_address_d = slot_a[1:0];
                        bus_write_d   = is_write_q;
                        to_cnt_d      = '0;
                        if (is_write_q) begin
                            bus_wdata_d = slot_d_in;
                        end
                    end else begin
                        state_d = ST_RELEASE;
                        wait_d  = 1'b0;
                    end
                end
            end
            ST_REQ: begin
                if (bus_ready) begin
                    state_d = is_write_q ? ST_RELEASE : ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                if (bus_rdata_en) begin
                    state_d = ST_RELEASE;
                    d_out_d = bus_rdata;
                    dir_d   = 1'b1;
                    wait_d  = 1'b0;
                end else if (to_hit) begin
                    state_d   = ST_RELEASE;
                    d_out_d   = 8'hFF;
                    dir_d     = 1'b1;
                    wait_d    = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (all_idle) begin
                    state_d = ST_IDLE;
                    dir_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus_valid     = (state_q == ST_REQ);
    assign bus_write     = bus_write_q;
    assign bus_address   = bus_address_q;
    assign bus_wdata     = bus_wdata_q;
    assign slot_d_out    = d_out_q;
    // Release the data bus in the same cycle the synced strobes are seen inactive.
    assign slot_data_dir = dir_q & ~((state_q == ST_RELEASE) & all_idle);
    assign slot_wait     = wait_q;
    assign timeout_flag  = timeout_q;

endmodule
